// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the pipeline MEM
// stage and a host/loader port. The pipeline normally owns the RAM; the host
// wins when the pipeline is idle or after STARVE_MAX consecutive denials.
//
// Handshake semantics (one place, applies to every port):
//   - Pipeline: p_req is a per-cycle request. If p_stall is high in that cycle
//     the access did not happen and the pipeline re-presents it next cycle.
//   - Host: h_req is held until h_gnt; the access happens in the cycle where
//     h_req && h_gnt are both high, and h_req may drop after that.
//   - Reads return exactly one cycle after acceptance on the requester's
//     *_rvalid/*_rdata pair; *_rdata holds its last value while *_rvalid is low.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // pipeline MEM stage
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [1:0]  p_size,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic        p_rvalid,
  output logic [31:0] p_rdata,
  output logic        p_misalign,
  // host / loader
  input  logic        h_req,
  input  logic        h_we,
  input  logic [31:0] h_addr,
  input  logic [3:0]  h_be,
  input  logic [31:0] h_wdata,
  output logic        h_gnt,
  output logic        h_rvalid,
  output logic [31:0] h_rdata,
  // RAM port
  output logic [12:0] m_addr,
  output logic [3:0]  m_wren,
  output logic        m_rden,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starveCnt;
  logic          hostWins;
  logic          pipeOwn;

  // decoded pipeline access
  logic [3:0]    pLanes;
  logic [31:0]   pData;
  logic          pMis;

  // owner tags and response registers
  logic          pRdTag;
  logic          hRdTag;
  logic          misQ;
  logic          misLoadQ;
  logic [31:0]   pHold;
  logic [31:0]   hHold;

  // Address bits outside the 32 KiB window and the host byte offset are
  // intentionally ignored.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{h_addr[31:15], h_addr[1:0], p_addr[31:15]};

  // Arbitration is purely combinational so reset never gates it.
  assign hostWins = h_req && (!p_req || (starveCnt == STARVE_LIM));
  assign h_gnt    = hostWins;
  assign p_stall  = p_req && hostWins;
  assign pipeOwn  = p_req && !hostWins;

  // Starvation counter: counts consecutive host denials, cleared on grant or idle host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (h_req && !hostWins) begin
      if (starveCnt != STARVE_LIM) starveCnt <= starveCnt + 1'b1;
    end else begin
      starveCnt <= '0;
    end
  end

  // Pipeline size/alignment decode: lane enables, replicated store data, misalign flag.
  always_comb begin
    pLanes = 4'b0000;
    pData  = p_wdata;
    pMis   = 1'b0;
    case (p_size)
      2'b00: begin
        pLanes = 4'b0001 << p_addr[1:0];
        pData  = {4{p_wdata[7:0]}};
      end
      2'b01: begin
        pLanes = p_addr[1] ? 4'b1100 : 4'b0011;
        pData  = {2{p_wdata[15:0]}};
        pMis   = p_addr[0];
      end
      2'b10: begin
        pLanes = 4'b1111;
        pMis   = |p_addr[1:0];
      end
      default: begin
        pLanes = 4'b0000;
        pMis   = 1'b1;
      end
    endcase
  end

  // RAM port mux: the granted source drives address, enables and write data.
  always_comb begin
    m_addr  = p_addr[14:2];
    m_wdata = pData;
    m_wren  = 4'b0000;
    m_rden  = 1'b0;
    if (hostWins) begin
      m_addr  = h_addr[14:2];
      m_wdata = h_wdata;
      if (h_we) m_wren = h_be;
      else      m_rden = 1'b1;
    end else if (pipeOwn && !pMis) begin
      if (p_we) m_wren = pLanes;
      else      m_rden = 1'b1;
    end
  end

  // Owner tags: remember who issued this cycle's read (or a rejected access) for the response cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pRdTag   <= 1'b0;
      hRdTag   <= 1'b0;
      misQ     <= 1'b0;
      misLoadQ <= 1'b0;
    end else begin
      pRdTag   <= pipeOwn && !pMis && !p_we;
      hRdTag   <= hostWins && !h_we;
      misQ     <= pipeOwn && pMis;
      misLoadQ <= pipeOwn && pMis && !p_we;
    end
  end

  // Response routing: RAM data goes straight through in the valid cycle, otherwise the held value.
  always_comb begin
    p_rvalid   = pRdTag || misLoadQ;
    p_misalign = misQ;
    h_rvalid   = hRdTag;
    if (pRdTag)        p_rdata = m_rdata;
    else if (misLoadQ) p_rdata = 32'h0000_0000;
    else               p_rdata = pHold;
    h_rdata = hRdTag ? m_rdata : hHold;
  end

  // Hold registers keep the last delivered word on each read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pHold <= 32'h0000_0000;
      hHold <= 32'h0000_0000;
    end else begin
      if (p_rvalid) pHold <= p_rdata;
      if (h_rvalid) hHold <= h_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven vectors for the combinational RAM-port
// decode plus hand-written sequences for starvation, alternating reads and
// reset during a read. Read responses are checked by a scoreboard.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_req = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [1:0]  p_size = '0;
  logic        p_stall, p_rvalid, p_misalign;
  logic [31:0] p_rdata;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic [3:0]  h_be = '0;
  logic        h_gnt, h_rvalid;
  logic [31:0] h_rdata;
  logic [12:0] m_addr;
  logic [3:0]  m_wren;
  logic        m_rden;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  int nChecks = 0;
  int nFail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_size(p_size), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_misalign(p_misalign),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_be(h_be), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
    .m_addr(m_addr), .m_wren(m_wren), .m_rden(m_rden), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // ---------------- RAM model: 1-cycle read, address-derived pattern ----------------
  function automatic logic [31:0] pat(input logic [12:0] a);
    return {3'b101, a, 3'b000, a};
  endfunction

  logic        rdQ = 1'b0;
  logic [12:0] rdAddrQ = '0;
  always @(posedge clk) begin
    rdQ <= m_rden;
    if (m_rden) rdAddrQ <= m_addr;
  end
  assign m_rdata = rdQ ? pat(rdAddrQ) : 32'hDEAD_BEEF;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] pExpQ[$];
  logic [31:0] hExpQ[$];
  logic [31:0] lastP = '0;
  logic [31:0] lastH = '0;
  logic        misExp = 1'b0;

  // Anything pushed at a rising edge must come out at the following falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    if (pExpQ.size() > 0) begin
      e = pExpQ.pop_front();
      chk("p_rvalid", {31'b0, p_rvalid}, 32'd1);
      chk("p_rdata", p_rdata, e);
      lastP = e;
    end else begin
      chk("p_rvalid_idle", {31'b0, p_rvalid}, 32'd0);
      chk("p_rdata_hold", p_rdata, lastP);
    end
    if (hExpQ.size() > 0) begin
      e = hExpQ.pop_front();
      chk("h_rvalid", {31'b0, h_rvalid}, 32'd1);
      chk("h_rdata", h_rdata, e);
      lastH = e;
    end else begin
      chk("h_rvalid_idle", {31'b0, h_rvalid}, 32'd0);
      chk("h_rdata_hold", h_rdata, lastH);
    end
    chk("p_misalign", {31'b0, p_misalign}, {31'b0, misExp});
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        pReq, pWe;
    logic [31:0] pAddr;
    logic [1:0]  pSize;
    logic [31:0] pWdata;
    logic        hReq, hWe;
    logic [31:0] hAddr;
    logic [3:0]  hBe;
    logic [31:0] hWdata;
    logic        eGnt, eStall;
    logic [12:0] eAddr;
    logic [3:0]  eWren;
    logic        eRden;
    logic [31:0] eWdata;
    logic        eMis, ePRead, eHRead;
  } vec_t;

  function automatic vec_t mk(
    input logic pReq, input logic pWe, input logic [31:0] pAddr, input logic [1:0] pSize,
    input logic [31:0] pWdata, input logic hReq, input logic hWe, input logic [31:0] hAddr,
    input logic [3:0] hBe, input logic [31:0] hWdata, input logic eGnt, input logic eStall,
    input logic [12:0] eAddr, input logic [3:0] eWren, input logic eRden,
    input logic [31:0] eWdata, input logic eMis, input logic ePRead, input logic eHRead);
    vec_t v;
    v.pReq = pReq; v.pWe = pWe; v.pAddr = pAddr; v.pSize = pSize; v.pWdata = pWdata;
    v.hReq = hReq; v.hWe = hWe; v.hAddr = hAddr; v.hBe = hBe; v.hWdata = hWdata;
    v.eGnt = eGnt; v.eStall = eStall; v.eAddr = eAddr; v.eWren = eWren; v.eRden = eRden;
    v.eWdata = eWdata; v.eMis = eMis; v.ePRead = ePRead; v.eHRead = eHRead;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    p_req = v.pReq; p_we = v.pWe; p_addr = v.pAddr; p_size = v.pSize; p_wdata = v.pWdata;
    h_req = v.hReq; h_we = v.hWe; h_addr = v.hAddr; h_be = v.hBe; h_wdata = v.hWdata;
  endtask

  // One cycle: drive at the falling edge, check the RAM port, queue expected reads at the rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    chk({tag, ".h_gnt"},   {31'b0, h_gnt},   {31'b0, v.eGnt});
    chk({tag, ".p_stall"}, {31'b0, p_stall}, {31'b0, v.eStall});
    chk({tag, ".m_addr"},  {19'b0, m_addr},  {19'b0, v.eAddr});
    chk({tag, ".m_wren"},  {28'b0, m_wren},  {28'b0, v.eWren});
    chk({tag, ".m_rden"},  {31'b0, m_rden},  {31'b0, v.eRden});
    chk({tag, ".m_wdata"}, m_wdata,          v.eWdata);
    @(posedge clk);
    if (v.ePRead) pExpQ.push_back(v.eMis ? 32'h0 : pat(v.eAddr));
    if (v.eHRead) hExpQ.push_back(pat(v.eAddr));
    misExp = v.eMis;
  endtask

  vec_t vecs[15];
  vec_t idle, sP, sH, pOnly, hRd20, pRd24, hRd30, pRd34, pRd10;

  initial begin
    idle  = mk(0,0,32'h0,2'b00,32'h0, 0,0,32'h0,4'h0,32'h0, 0,0,13'h0,4'b0000,0,32'h0, 0,0,0);
    // pipeline word store vs host write, for starvation
    sP    = mk(1,1,32'h8,2'b10,32'h01020304, 1,1,32'h40,4'hF,32'hFFFF0000,
               0,0,13'h2,4'b1111,0,32'h01020304, 0,0,0);
    sH    = mk(1,1,32'h8,2'b10,32'h01020304, 1,1,32'h40,4'hF,32'hFFFF0000,
               1,1,13'h10,4'b1111,0,32'hFFFF0000, 0,0,0);
    pOnly = mk(1,1,32'h8,2'b10,32'h01020304, 0,0,32'h0,4'h0,32'h0,
               0,0,13'h2,4'b1111,0,32'h01020304, 0,0,0);
    hRd20 = mk(0,0,32'h0,2'b10,32'h0, 1,0,32'h20,4'h0,32'h0, 1,0,13'h8,4'b0000,1,32'h0, 0,0,1);
    pRd24 = mk(1,0,32'h24,2'b10,32'h0, 0,0,32'h0,4'h0,32'h0, 0,0,13'h9,4'b0000,1,32'h0, 0,1,0);
    hRd30 = mk(0,0,32'h0,2'b10,32'h0, 1,0,32'h30,4'h0,32'h0, 1,0,13'hC,4'b0000,1,32'h0, 0,0,1);
    pRd34 = mk(1,0,32'h34,2'b10,32'h0, 0,0,32'h0,4'h0,32'h0, 0,0,13'hD,4'b0000,1,32'h0, 0,1,0);
    pRd10 = mk(1,0,32'h10,2'b10,32'h0, 0,0,32'h0,4'h0,32'h0, 0,0,13'h4,4'b0000,1,32'h0, 0,1,0);

    vecs[0]  = pRd10;
    vecs[1]  = mk(1,1,32'h7,2'b00,32'hA5, 0,0,0,0,0, 0,0,13'h1,4'b1000,0,32'hA5A5A5A5, 0,0,0);
    vecs[2]  = mk(1,1,32'h4,2'b00,32'hFFFFFF3C, 0,0,0,0,0, 0,0,13'h1,4'b0001,0,32'h3C3C3C3C, 0,0,0);
    vecs[3]  = mk(1,1,32'h6,2'b01,32'h1111BEEF, 0,0,0,0,0, 0,0,13'h1,4'b1100,0,32'hBEEFBEEF, 0,0,0);
    vecs[4]  = mk(1,1,32'h100,2'b01,32'h1234, 0,0,0,0,0, 0,0,13'h40,4'b0011,0,32'h12341234, 0,0,0);
    vecs[5]  = mk(1,1,32'h7FFC,2'b10,32'hCAFEF00D, 0,0,0,0,0, 0,0,13'h1FFF,4'b1111,0,32'hCAFEF00D, 0,0,0);
    vecs[6]  = mk(1,0,32'h3,2'b01,32'h0, 0,0,0,0,0, 0,0,13'h0,4'b0000,0,32'h0, 1,1,0);
    vecs[7]  = mk(1,1,32'h2,2'b10,32'h11223344, 0,0,0,0,0, 0,0,13'h0,4'b0000,0,32'h11223344, 1,0,0);
    vecs[8]  = mk(1,0,32'h0,2'b11,32'h0, 0,0,0,0,0, 0,0,13'h0,4'b0000,0,32'h0, 1,1,0);
    vecs[9]  = mk(0,0,32'h0,2'b00,32'h0, 1,1,32'h23,4'b0101,32'h55AA55AA,
                  1,0,13'h8,4'b0101,0,32'h55AA55AA, 0,0,0);
    vecs[10] = hRd20;
    vecs[11] = mk(1,1,32'h40,2'b10,32'h01010101, 1,1,32'h40,4'hF,32'hFFFFFFFF,
                  0,0,13'h10,4'b1111,0,32'h01010101, 0,0,0);
    vecs[12] = mk(1,0,32'h80000014,2'b10,32'h0, 0,0,0,0,0, 0,0,13'h5,4'b0000,1,32'h0, 0,1,0);
    vecs[13] = mk(1,0,32'h1,2'b00,32'h0, 0,0,0,0,0, 0,0,13'h0,4'b0000,1,32'h0, 0,1,0);
    vecs[14] = mk(0,0,32'h0,2'b00,32'h0, 1,0,32'h7FFFFFFC,4'hF,32'h0,
                  1,0,13'h1FFF,4'b0000,1,32'h0, 0,0,1);

    // reset state: the monitor checks zeroed outputs at these falling edges
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // table-driven vectors, each followed by an idle cycle
    for (int i = 0; i < 15; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
      apply($sformatf("idle%0d", i), idle);
    end

    // starvation: host wins on the fifth contested cycle, counter restarts
    for (int i = 0; i < 10; i++)
      apply($sformatf("starve%0d", i), (i == 4 || i == 9) ? sH : sP);
    // a cycle with h_req low clears the count
    apply("clr0", sP); apply("clr1", sP); apply("clr2", sP);
    apply("clr3", pOnly);
    for (int i = 0; i < 4; i++) apply($sformatf("clr_den%0d", i), sP);
    apply("clr_gnt", sH);
    apply("idle_s", idle);

    // alternating owners, back-to-back reads
    apply("alt0", hRd20);
    apply("alt1", pRd24);
    apply("alt2", hRd30);
    apply("alt3", pRd34);
    apply("alt4", idle);

    // reset asserted while a read is being issued
    @(negedge clk);
    drive(pRd10);
    #3;
    rst   = 1'b1;
    lastP = '0;
    lastH = '0;
    #1;
    chk("rst_m_rden", {31'b0, m_rden}, 32'd1);
    chk("rst_m_addr", {19'b0, m_addr}, 32'd4);
    @(posedge clk);
    misExp = 1'b0;
    @(negedge clk);
    drive(idle);
    @(negedge clk);
    #1 rst = 1'b0;
    apply("post_rst", pRd10);
    apply("post_idle0", idle);
    apply("post_idle1", idle);

    chk("p_queue_empty", pExpQ.size(), 32'd0);
    chk("h_queue_empty", hExpQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
